// File: rtl/longdiv_pkg.sv
// longdiv_pkg: FSM state encoding and default sizes shared by the longdiv_scheduler files
package longdiv_pkg;
  localparam int DEF_N_REQ = 2;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/longdiv_scheduler_if.sv
// longdiv_scheduler_if: client-side req/gnt/response bus of the shared divider scheduler
// DIVZERO_CHECK_EN adds the rsp_dz divide-by-zero flag.
interface longdiv_scheduler_if
  import longdiv_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_A;
  logic [N_REQ*WIDTH-1:0] req_B;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_Q;
  logic [WIDTH-1:0]       rsp_R;
  logic                   busy;
`ifdef DIVZERO_CHECK_EN
  logic                   rsp_dz;
  modport master (output req, req_A, req_B, input gnt, rsp_valid, rsp_Q, rsp_R, busy, rsp_dz);
  modport slave  (input req, req_A, req_B, output gnt, rsp_valid, rsp_Q, rsp_R, busy, rsp_dz);
`else
  modport master (output req, req_A, req_B, input gnt, rsp_valid, rsp_Q, rsp_R, busy);
  modport slave  (input req, req_A, req_B, output gnt, rsp_valid, rsp_Q, rsp_R, busy);
`endif
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap-around
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[(int'(ptr) + k) % N_REQ]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % N_REQ);
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/longdiv_scheduler.sv
// longdiv_scheduler: round-robin sharing of one longdivider among N_REQ requesters
// DIVZERO_CHECK_EN answers B==0 requests locally without touching the divider.
module longdiv_scheduler
  import longdiv_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  longdiv_scheduler_if.slave bus,
  output logic               div_Resetn,
  output logic               div_LA,
  output logic               div_EB,
  output logic               div_s,
  output logic [WIDTH-1:0]   div_DataA,
  output logic [WIDTH-1:0]   div_DataB,
  input  logic [WIDTH-1:0]   div_Q,
  input  logic [WIDTH-1:0]   div_R,
  input  logic               div_Done
);
  localparam int IW = $clog2(N_REQ);
  state_t           state;
  logic [IW-1:0]    ptr, id, win_idx;
  logic [N_REQ-1:0] win;
  logic             any, done_armed, dz;
  logic [WIDTH-1:0] win_a, win_b;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (.req(bus.req), .ptr, .gnt(win), .idx(win_idx), .any);
  assign win_a      = bus.req_A[win_idx*WIDTH +: WIDTH];
  assign win_b      = bus.req_B[win_idx*WIDTH +: WIDTH];
  assign div_Resetn = ~Reset;
  assign bus.busy   = state != S_IDLE;
`ifdef DIVZERO_CHECK_EN
  assign dz = win_b == '0;
`else
  assign dz = 1'b0;
`endif
  // RESP also arbitrates so a new grant can follow the response immediately
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      id            <= '0;
      done_armed    <= 1'b0;
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_Q     <= '0;
      bus.rsp_R     <= '0;
      div_LA        <= 1'b0;
      div_EB        <= 1'b0;
      div_s         <= 1'b0;
      div_DataA     <= '0;
      div_DataB     <= '0;
`ifdef DIVZERO_CHECK_EN
      bus.rsp_dz    <= 1'b0;
`endif
    end else begin
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      div_LA        <= 1'b0;
      div_EB        <= 1'b0;
      div_s         <= 1'b0;
`ifdef DIVZERO_CHECK_EN
      bus.rsp_dz    <= 1'b0;
`endif
      case (state)
        S_LOAD: begin
          div_LA <= 1'b1;
          div_EB <= 1'b1;
          state  <= S_START;
        end
        S_START: begin
          div_s      <= 1'b1;
          done_armed <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // a Done still high from the previous op is ignored until Done has been seen low
          if (div_Done && done_armed) begin
            bus.rsp_Q     <= div_Q;
            bus.rsp_R     <= div_R;
            bus.rsp_valid <= N_REQ'(1) << id;
            ptr           <= nxt(id);
            state         <= S_RESP;
          end else if (!div_Done) done_armed <= 1'b1;
        end
        default: begin
          state <= any ? S_LOAD : S_IDLE;
          if (any) begin
            bus.gnt <= win;
            id      <= win_idx;
          end
          if (any && !dz) begin
            div_DataA <= win_a;
            div_DataB <= win_b;
          end
`ifdef DIVZERO_CHECK_EN
          if (any && dz) begin
            bus.rsp_Q     <= '1;
            bus.rsp_R     <= win_a;
            bus.rsp_valid <= win;
            bus.rsp_dz    <= 1'b1;
            ptr           <= nxt(win_idx);
            state         <= S_RESP;
          end
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_longdiv_scheduler.sv
// tb_longdiv_scheduler: directed checks of longdiv_scheduler against a slow-Done divider model
module tb_longdiv_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       div_Resetn, div_LA, div_EB, div_s, div_Done;
  logic [7:0] div_DataA, div_DataB, div_Q, div_R, ma, mb;
  int         cnt = 0;
  int         la_cnt = 0;
  bit         hold_stale = 1'b0;
  int         errors = 0;
  int         checks = 0;

  longdiv_scheduler_if #(.N_REQ(2), .WIDTH(8)) bus ();

  longdiv_scheduler #(.N_REQ(2), .WIDTH(8)) dut (
    .Clock(clk), .Reset(rst), .bus(bus),
    .div_Resetn(div_Resetn), .div_LA(div_LA), .div_EB(div_EB), .div_s(div_s),
    .div_DataA(div_DataA), .div_DataB(div_DataB),
    .div_Q(div_Q), .div_R(div_R), .div_Done(div_Done)
  );

  always #5 clk = ~clk;

  // Divider model: Done drops on start (or 3 cycles later when hold_stale), result after 5 cycles
  always @(posedge clk) begin
    if (!div_Resetn) begin
      div_Done <= 1'b0;
      cnt      <= 0;
      div_Q    <= '0;
      div_R    <= '0;
      ma       <= '0;
      mb       <= '0;
    end else begin
      if (div_LA) ma <= div_DataA;
      if (div_EB) mb <= div_DataB;
      if (div_s) begin
        cnt <= 5;
        if (!hold_stale) div_Done <= 1'b0;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 2) div_Done <= 1'b0;
        if (cnt == 1) begin
          div_Done <= 1'b1;
          div_Q    <= (mb == 0) ? 8'hff : ma / mb;
          div_R    <= (mb == 0) ? ma : ma % mb;
        end
      end
    end
  end

  always @(posedge clk) if (div_LA) la_cnt <= la_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_A[i*8 +: 8] = a;
    bus.req_B[i*8 +: 8] = b;
  endtask

  task automatic wait_gnt(input bit drop, output logic [1:0] g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 60);
    if (bus.gnt == '0) check("gnt_timeout", 0, 1);
    g = bus.gnt;
    if (drop) bus.req = bus.req & ~g;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rsp_valid == '0 && n < 60);
    if (bus.rsp_valid == '0) check({tag, "_rsp_timeout"}, 0, 1);
  endtask

  initial begin
    logic [1:0] g;
    logic       seen;
    int         la0;
    rst = 1'b1;
    bus.req = '0;
    bus.req_A = '0;
    bus.req_B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_q", 32'(bus.rsp_Q), 0);
    check("rst_r", 32'(bus.rsp_R), 0);
    check("rst_la", 32'(div_LA), 0);
    check("rst_s", 32'(div_s), 0);
    check("rst_da", 32'(div_DataA), 0);
    check("rst_resetn", 32'(div_Resetn), 0);
    rst = 1'b0;
    // 1) single request, cycle-exact handshake
    set_op(0, 15, 2);
    bus.req = 2'b01;
    wait_gnt(1, g);
    check("t1_gnt", 32'(g), 1);
    check("t1_busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("t1_la", 32'(div_LA), 1);
    check("t1_eb", 32'(div_EB), 1);
    check("t1_da", 32'(div_DataA), 15);
    check("t1_db", 32'(div_DataB), 2);
    check("t1_gnt_pulse", 32'(bus.gnt), 0);
    @(negedge clk);
    check("t1_s", 32'(div_s), 1);
    check("t1_la_pulse", 32'(div_LA), 0);
    wait_rsp("t1");
    check("t1_valid", 32'(bus.rsp_valid), 1);
    check("t1_q", 32'(bus.rsp_Q), 7);
    check("t1_r", 32'(bus.rsp_R), 1);
`ifdef DIVZERO_CHECK_EN
    check("t1_dz", 32'(bus.rsp_dz), 0);
`endif
    @(negedge clk);
    check("t1_valid_pulse", 32'(bus.rsp_valid), 0);
    check("t1_q_hold", 32'(bus.rsp_Q), 7);
    // 2) simultaneous requests after reset: requester 0 first
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_op(0, 100, 7);
    set_op(1, 9, 3);
    bus.req = 2'b11;
    wait_gnt(1, g);
    check("t2_gnt0", 32'(g), 1);
    wait_rsp("t2a");
    check("t2_valid0", 32'(bus.rsp_valid), 1);
    check("t2_q0", 32'(bus.rsp_Q), 14);
    check("t2_r0", 32'(bus.rsp_R), 2);
    wait_gnt(1, g);
    check("t2_gnt1", 32'(g), 2);
    wait_rsp("t2b");
    check("t2_valid1", 32'(bus.rsp_valid), 2);
    check("t2_q1", 32'(bus.rsp_Q), 3);
    check("t2_r1", 32'(bus.rsp_R), 0);
    // 3) both requesting continuously: grants alternate
    set_op(0, 50, 5);
    set_op(1, 17, 4);
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(0, g);
      check("t3_gnt", 32'(g), (k % 2 == 0) ? 1 : 2);
      wait_rsp("t3");
      check("t3_q", 32'(bus.rsp_Q), (k % 2 == 0) ? 10 : 4);
      check("t3_r", 32'(bus.rsp_R), (k % 2 == 0) ? 0 : 1);
      if (k == 3) bus.req = '0;
    end
    // 4) Done held high from previous op: stale 4/1 must not be captured
    hold_stale = 1'b1;
    set_op(0, 60, 7);
    bus.req = 2'b01;
    wait_gnt(1, g);
    check("t4_gnt", 32'(g), 1);
    wait_rsp("t4");
    check("t4_q", 32'(bus.rsp_Q), 8);
    check("t4_r", 32'(bus.rsp_R), 4);
    hold_stale = 1'b0;
    // 5) reset in WAIT abandons the op
    set_op(1, 30, 4);
    bus.req = 2'b10;
    wait_gnt(1, g);
    check("t5_gnt", 32'(g), 2);
    repeat (3) @(negedge clk);
    check("t5_busy_wait", 32'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_s", 32'(div_s), 0);
    check("t5_da", 32'(div_DataA), 0);
    check("t5_q", 32'(bus.rsp_Q), 0);
    check("t5_resetn", 32'(div_Resetn), 0);
    seen = |bus.rsp_valid;
    @(negedge clk);
    seen = seen | (|bus.rsp_valid);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | (|bus.rsp_valid);
    end
    check("t5_no_rsp", 32'(seen), 0);
    bus.req = 2'b10;
    wait_gnt(1, g);
    check("t5_regnt", 32'(g), 2);
    wait_rsp("t5");
    check("t5_valid", 32'(bus.rsp_valid), 2);
    check("t5_q2", 32'(bus.rsp_Q), 7);
    check("t5_r2", 32'(bus.rsp_R), 2);
    // 6) divide by zero
    set_op(0, 200, 0);
    la0 = la_cnt;
    bus.req = 2'b01;
    wait_gnt(1, g);
    check("t6_gnt", 32'(g), 1);
`ifdef DIVZERO_CHECK_EN
    check("t6_valid", 32'(bus.rsp_valid), 1);
    check("t6_q", 32'(bus.rsp_Q), 255);
    check("t6_r", 32'(bus.rsp_R), 200);
    check("t6_dz", 32'(bus.rsp_dz), 1);
    repeat (3) @(negedge clk);
    check("t6_dz_pulse", 32'(bus.rsp_dz), 0);
    check("t6_no_la", 32'(la_cnt - la0), 0);
`else
    @(negedge clk);
    check("t6_la", 32'(div_LA), 1);
    check("t6_db", 32'(div_DataB), 0);
    wait_rsp("t6");
    check("t6_valid", 32'(bus.rsp_valid), 1);
    check("t6_q", 32'(bus.rsp_Q), 255);
    check("t6_r", 32'(bus.rsp_R), 200);
    check("t6_one_la", 32'(la_cnt - la0), 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
